// File: rtl/game_tick_scheduler_if.sv
// Bundles the game-side inputs and the strobe/fire outputs of game_tick_scheduler.
// master = the scheduler, slave = game logic consuming the strobes.
interface game_tick_scheduler_if #(
  parameter int CNT_W = 24
);
  logic             pause;
  logic [3:0]       level;
  logic             fire_req;
  logic             tick_25MHz;
  logic             tick_ship;
  logic             tick_projectile;
  logic             tick_alien;
  logic             fire_grant;
  logic             cooldown_active;
  logic [CNT_W-1:0] alien_div_cur;

  modport master (
    input  pause, level, fire_req,
    output tick_25MHz, tick_ship, tick_projectile, tick_alien,
    output fire_grant, cooldown_active, alien_div_cur
  );

  modport slave (
    output pause, level, fire_req,
    input  tick_25MHz, tick_ship, tick_projectile, tick_alien,
    input  fire_grant, cooldown_active, alien_div_cur
  );
endinterface

// File: rtl/game_tick_scheduler.sv
// Single-clock game timing: prescaled clock-enable strobes, level-scaled alien
// period and the fire/cooldown handshake. Pause freezes game timing, not pixels.
module game_tick_scheduler #(
  parameter int CNT_W          = 24,
  parameter int PIX_DIV        = 4,
  parameter int SHIP_DIV       = 500000,
  parameter int PROJ_DIV       = 250000,
  parameter int ALIEN_DIV_BASE = 5000000,
  parameter int ALIEN_DIV_STEP = 500000,
  parameter int ALIEN_DIV_MIN  = 1000000,
  parameter int CD_DIV         = 1000000,
  parameter int CD_TICKS       = 50,
  parameter int AUTOFIRE       = 0
) (
  input  logic                  master_clk,
  input  logic                  RESET_debounced,
  game_tick_scheduler_if.master bus
);

  localparam int TW    = CNT_W + 4;
  localparam int CDT_W = $clog2(CD_TICKS + 1);

  localparam logic signed [TW-1:0] ALIEN_BASE_S = TW'(ALIEN_DIV_BASE);
  localparam logic signed [TW-1:0] ALIEN_STEP_S = TW'(ALIEN_DIV_STEP);
  localparam logic signed [TW-1:0] ALIEN_MIN_S  = TW'(ALIEN_DIV_MIN);

  typedef enum logic [1:0] {
    READY        = 2'd0,
    COOLDOWN     = 2'd1,
    WAIT_RELEASE = 2'd2
  } fire_state_t;

  // Signed headroom keeps high levels from wrapping below zero before the floor.
  function automatic logic [CNT_W-1:0] sat_alien_div(input logic [3:0] lvl);
    logic signed [TW-1:0] lvl_s;
    logic signed [TW-1:0] diff_s;
    lvl_s  = $signed({{(TW-4){1'b0}}, lvl});
    diff_s = ALIEN_BASE_S - (lvl_s * ALIEN_STEP_S);
    if (diff_s < ALIEN_MIN_S) sat_alien_div = CNT_W'(ALIEN_DIV_MIN);
    else                      sat_alien_div = diff_s[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] r_pix_cnt;
  logic [CNT_W-1:0] r_ship_cnt;
  logic [CNT_W-1:0] r_proj_cnt;
  logic [CNT_W-1:0] r_alien_cnt;
  logic [CNT_W-1:0] r_alien_div;
  logic [CNT_W-1:0] r_cd_cnt;
  logic [CDT_W-1:0] r_cd_ticks;
  logic             r_tick_pix;
  logic             r_tick_ship;
  logic             r_tick_proj;
  logic             r_tick_alien;
  logic             r_fire_grant;
  fire_state_t      r_state;

  fire_state_t      w_state_nxt;
  logic             w_grant_nxt;
  logic             w_cd_clr;
  logic             w_pix_wrap;
  logic             w_ship_wrap;
  logic             w_proj_wrap;
  logic             w_alien_wrap;
  logic             w_cd_wrap;
  logic             w_cd_done;
  logic [CNT_W-1:0] w_alien_tgt;

  assign w_pix_wrap   = (r_pix_cnt   == CNT_W'(PIX_DIV - 1));
  assign w_ship_wrap  = (r_ship_cnt  == CNT_W'(SHIP_DIV - 1));
  assign w_proj_wrap  = (r_proj_cnt  == CNT_W'(PROJ_DIV - 1));
  assign w_alien_wrap = (r_alien_cnt == (r_alien_div - CNT_W'(1)));
  assign w_cd_wrap    = (r_cd_cnt    == CNT_W'(CD_DIV - 1));
  assign w_cd_done    = (r_state == COOLDOWN) && w_cd_wrap &&
                        (r_cd_ticks == CDT_W'(CD_TICKS - 1));
  assign w_alien_tgt  = sat_alien_div(bus.level);

  // Pixel prescaler: free-running, never paused.
  always_ff @(posedge master_clk) begin
    if (RESET_debounced) begin
      r_pix_cnt  <= '0;
      r_tick_pix <= 1'b0;
    end else begin
      r_tick_pix <= w_pix_wrap;
      r_pix_cnt  <= w_pix_wrap ? '0 : r_pix_cnt + CNT_W'(1);
    end
  end

  // Game prescalers: every register freezes while paused, so a strobe set just
  // before pause is emitted after release instead of being dropped.
  always_ff @(posedge master_clk) begin
    if (RESET_debounced) begin
      r_ship_cnt   <= '0;
      r_proj_cnt   <= '0;
      r_alien_cnt  <= '0;
      r_alien_div  <= CNT_W'(ALIEN_DIV_BASE);
      r_tick_ship  <= 1'b0;
      r_tick_proj  <= 1'b0;
      r_tick_alien <= 1'b0;
    end else if (!bus.pause) begin
      r_tick_ship  <= w_ship_wrap;
      r_tick_proj  <= w_proj_wrap;
      r_tick_alien <= w_alien_wrap;
      r_ship_cnt   <= w_ship_wrap ? '0 : r_ship_cnt + CNT_W'(1);
      r_proj_cnt   <= w_proj_wrap ? '0 : r_proj_cnt + CNT_W'(1);
      if (w_alien_wrap) begin
        r_alien_cnt <= '0;
        r_alien_div <= w_alien_tgt;
      end else begin
        r_alien_cnt <= r_alien_cnt + CNT_W'(1);
      end
    end
  end

  // Cooldown prescaler and tick count, cleared on each grant.
  always_ff @(posedge master_clk) begin
    if (RESET_debounced) begin
      r_cd_cnt     <= '0;
      r_cd_ticks   <= '0;
      r_fire_grant <= 1'b0;
    end else if (!bus.pause) begin
      r_fire_grant <= w_grant_nxt;
      if (w_cd_clr) begin
        r_cd_cnt   <= '0;
        r_cd_ticks <= '0;
      end else if (r_state == COOLDOWN) begin
        if (w_cd_wrap) begin
          r_cd_cnt   <= '0;
          r_cd_ticks <= r_cd_ticks + CDT_W'(1);
        end else begin
          r_cd_cnt <= r_cd_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge master_clk) begin
    if (RESET_debounced) r_state <= READY;
    else                 r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = 1'b0;
    w_cd_clr    = 1'b0;
    case (r_state)
      READY: begin
        if (bus.fire_req && !bus.pause) begin
          w_grant_nxt = 1'b1;
          w_cd_clr    = 1'b1;
          w_state_nxt = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (!bus.pause && w_cd_done) begin
          if (AUTOFIRE != 0)     w_state_nxt = READY;
          else if (bus.fire_req) w_state_nxt = WAIT_RELEASE;
          else                   w_state_nxt = READY;
        end
      end
      WAIT_RELEASE: begin
        if (!bus.fire_req) w_state_nxt = READY;
      end
      default: w_state_nxt = READY;
    endcase
  end

  assign bus.tick_25MHz      = r_tick_pix;
  assign bus.tick_ship       = r_tick_ship  & ~bus.pause;
  assign bus.tick_projectile = r_tick_proj  & ~bus.pause;
  assign bus.tick_alien      = r_tick_alien & ~bus.pause;
  assign bus.fire_grant      = r_fire_grant & ~bus.pause;
  assign bus.cooldown_active = (r_state != READY);
  assign bus.alien_div_cur   = r_alien_div;

endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
- Central timing controller for the game: a single-clock replacement for the derived game clocks.
- Generates single-cycle clock-enable strobes on master_clk for the pixel pipeline, ship, projectiles and aliens.
- Sequences the fire/cooldown handshake between the fire button and the projectile logic.
- Alien speed scales with level; a pause input freezes all game timing but not pixel timing.

Parameters:
- CNT_W, 24, width of all prescaler counters.
- PIX_DIV, 4, master_clk cycles per tick_25MHz strobe (100 MHz -> 25 MHz).
- SHIP_DIV, 500000, cycles per tick_ship.
- PROJ_DIV, 250000, cycles per tick_projectile.
- ALIEN_DIV_BASE, 5000000, alien period at level 0.
- ALIEN_DIV_STEP, 500000, alien period reduction per level.
- ALIEN_DIV_MIN, 1000000, floor on alien period.
- CD_DIV, 1000000, cycles per cooldown tick (100 Hz).
- CD_TICKS, 50, cooldown ticks between shots.
- AUTOFIRE, 0; 1 = held button refires after cooldown, 0 = release required.

Ports:
- master_clk  in  1  system clock; sole clock.
- RESET_debounced  in  1  synchronous active-high reset.
- pause  in  1  level; freezes game ticks and cooldown.
- level  in  4  current game level, 0..15.
- fire_req  in  1  debounced fire button, level-sensitive.
- tick_25MHz  out  1  pixel enable strobe.
- tick_ship  out  1  ship update strobe.
- tick_projectile  out  1  projectile update strobe.
- tick_alien  out  1  alien update strobe.
- fire_grant  out  1  one-cycle pulse; spawn projectile.
- cooldown_active  out  1  high while a shot is blocked.
- alien_div_cur  out  CNT_W  alien period currently in use.

Behaviour:
- Clock and reset: one clock, master_clk. Reset is RESET_debounced, synchronous and active-high.
- Reset values: all counters 0, all strobes 0, fire_grant 0, cooldown_active 0, FSM READY, alien_div_cur = ALIEN_DIV_BASE. Reset asserted mid-operation wins over every other event and takes effect on the next edge.
- Prescaler (each of pix, ship, proj, alien):
  - Counter runs 0..DIV-1, then wraps to 0.
  - Strobe is registered and asserts for exactly one cycle in the cycle after the counter equals DIV-1.
  - After reset release, the first strobe appears at cycle DIV (1-based).
- Pause:
  - pause=1 holds the ship/proj/alien/cooldown counters and forces those strobes and fire_grant to 0.
  - The pix counter ignores pause.
  - Deasserting pause resumes counting from the held values; no strobe is lost or duplicated.
- Alien period:
  - target = ALIEN_DIV_BASE - level*ALIEN_DIV_STEP, saturated at ALIEN_DIV_MIN. Compute with CNT_W+4 bit signed arithmetic; no underflow wrap.
  - alien_div_cur loads target only on the cycle the alien counter wraps, so an in-flight period is never truncated.
  - Level changes between wraps take effect at the next wrap; only the last value counts.
- Fire FSM:
  - READY: cooldown_active=0. If fire_req=1 and pause=0, pulse fire_grant for 1 cycle, clear the cooldown prescaler and tick count, and go to COOLDOWN.
  - COOLDOWN: cooldown_active=1. The cooldown prescaler runs (held when paused) and each CD_DIV wrap increments the tick count. On reaching CD_TICKS:
    - AUTOFIRE=1: go to READY.
    - AUTOFIRE=0 with fire_req=1: go to WAIT_RELEASE.
    - Otherwise: go to READY.
  - WAIT_RELEASE: cooldown_active=1; go to READY when fire_req=0.
  - Back-to-back grants are separated by at least CD_DIV*CD_TICKS+1 cycles.
  - fire_req pulses during COOLDOWN are ignored and not queued.
- Simultaneous strobes on the same cycle are allowed and are independent.

Test Plan (bench overrides PIX_DIV=4, SHIP_DIV=5, PROJ_DIV=3, ALIEN_DIV_BASE=20, ALIEN_DIV_STEP=4, ALIEN_DIV_MIN=8, CD_DIV=2, CD_TICKS=3):
- Reset release, run 60 cycles -> tick_25MHz at cycles 4,8,12,...; tick_ship every 5; tick_projectile every 3; tick_alien at 20,40,60; all strobes exactly 1 cycle wide.
- level=1 set at cycle 10 -> next alien wrap still at 20; alien_div_cur becomes 16 there; next tick_alien at 36. level=5 -> alien_div_cur saturates at 8 (not underflowed).
- pause high for cycles 7..16 -> tick_25MHz unchanged; ship/proj/alien strobes absent during pause, then the phase is shifted by exactly 10 cycles after release.
- fire_req held high from reset, AUTOFIRE=0 -> one fire_grant; cooldown_active stays high past the 6-cycle cooldown until release; next press grants on the following cycle.
- AUTOFIRE=1, fire_req held -> fire_grant pulses spaced exactly 7 cycles apart; a fire_req toggle during cooldown produces no extra grant.
- RESET_debounced asserted during COOLDOWN with counters mid-count -> next cycle all outputs 0, alien_div_cur=20, FSM READY; first ship strobe again at cycle 5 after release.
